// File: rtl/axis_frame_padder_pkg.sv
// -----------------------------------------------------------------------------
// axis_pad_pkg
// Shared definitions for the AXI-Stream frame padder: FSM state encoding,
// default datapath/counter widths and the default fill word.
// No ports (package).
// -----------------------------------------------------------------------------
package axis_pad_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int CNT_W_DEF  = 32;

  // Fill word emitted during pad beats when the top-level default is kept.
  localparam logic [DATA_W_DEF-1:0] PAD_WORD_DEF = '1;

  typedef enum logic [1:0] {
    ST_PASS = 2'd0,
    ST_PAD  = 2'd1,
    ST_DROP = 2'd2
  } pad_state_e;

endpackage

// File: rtl/axis_frame_padder_if.sv
// -----------------------------------------------------------------------------
// axis_frame_padder_if
// AXI-Stream handshake bundle (tvalid/tready/tdata/tlast).
//   master modport : drives tvalid, tdata, tlast; receives tready
//   slave  modport : receives tvalid, tdata, tlast; drives tready
// Parameter DATA_W sets the tdata width.
// -----------------------------------------------------------------------------
interface axis_frame_padder_if
  import axis_pad_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic              tlast;

  modport master (
    output tvalid,
    output tdata,
    output tlast,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata,
    input  tlast,
    output tready
  );

endinterface

// File: rtl/axis_skid_reg.sv
// -----------------------------------------------------------------------------
// axis_skid_reg
// Two-entry registered skid buffer carrying tdata and tlast. Both the output
// side and the input ready are driven from flops, so there is no
// combinational path from out_ready to in_ready, yet a beat per cycle flows
// while out_ready stays high.
// Ports:
//   clk, srst                    : clock, synchronous active-high reset
//   in_valid/in_ready            : upstream handshake (in_ready registered)
//   in_data/in_last              : upstream payload
//   out_valid/out_ready          : downstream handshake
//   out_data/out_last            : downstream payload (registered)
// -----------------------------------------------------------------------------
module axis_skid_reg #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  logic              out_valid_reg;
  logic [DATA_W-1:0] out_data_reg;
  logic              out_last_reg;
  logic              skid_valid_reg;
  logic              skid_valid_next;
  logic [DATA_W-1:0] skid_data_reg;
  logic              skid_last_reg;
  logic              in_ready_reg;
  logic              accept;
  logic              out_load;

  assign accept   = in_valid & in_ready_reg;
  // The output register may take a new beat when empty or being drained.
  assign out_load = ~out_valid_reg | out_ready;

  always_comb begin
    skid_valid_next = skid_valid_reg;
    if (out_load) begin
      skid_valid_next = 1'b0;
    end else if (accept) begin
      skid_valid_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      out_valid_reg  <= 1'b0;
      out_data_reg   <= '0;
      out_last_reg   <= 1'b0;
      skid_valid_reg <= 1'b0;
      skid_data_reg  <= '0;
      skid_last_reg  <= 1'b0;
      in_ready_reg   <= 1'b0;
    end else begin
      skid_valid_reg <= skid_valid_next;
      // Ready for next cycle depends only on whether the spare slot is free.
      in_ready_reg   <= ~skid_valid_next;
      if (!out_load && accept) begin
        skid_data_reg <= in_data;
        skid_last_reg <= in_last;
      end
      if (out_load) begin
        if (skid_valid_reg) begin
          out_valid_reg <= 1'b1;
          out_data_reg  <= skid_data_reg;
          out_last_reg  <= skid_last_reg;
        end else if (accept) begin
          out_valid_reg <= 1'b1;
          out_data_reg  <= in_data;
          out_last_reg  <= in_last;
        end else begin
          out_valid_reg <= 1'b0;
        end
      end
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_last  = out_last_reg;

endmodule

// File: rtl/axis_frame_padder.sv
// -----------------------------------------------------------------------------
// axis_frame_padder
// Normalises every AXI-Stream frame to frame_len beats (0 treated as 1).
// Short frames are extended with PAD_WORD; long frames pass through
// unchanged, or, when AXIS_PAD_TRUNC_EN is defined, are cut to frame_len
// beats and the remainder of the input frame is discarded.
// Build macro: AXIS_PAD_TRUNC_EN (truncation + drop_beats port).
// Ports:
//   s_axis_aclk, s_axis_areset : clock, synchronous active-high reset
//   frame_len                  : target beats per frame, sampled on first beat
//   s_axis (slave modport)     : input stream
//   m_axis (master modport)    : output stream, driven from skid registers
//   m_axis_hsked               : output handshake indicator
//   frame_done                 : pulse when a frame's final beat is taken
//   pad_beats                  : pad beats inserted in last completed frame
//   drop_beats                 : input beats dropped in last completed frame
//                                (AXIS_PAD_TRUNC_EN only)
// -----------------------------------------------------------------------------
module axis_frame_padder
  import axis_pad_pkg::*;
#(
  parameter int                DATA_W   = DATA_W_DEF,
  parameter int                CNT_W    = CNT_W_DEF,
  parameter logic [DATA_W-1:0] PAD_WORD = {DATA_W{1'b1}}
) (
  input  logic               s_axis_aclk,
  input  logic               s_axis_areset,
  input  logic [CNT_W-1:0]   frame_len,
  axis_frame_padder_if.slave  s_axis,
  axis_frame_padder_if.master m_axis,
  output logic               m_axis_hsked,
  output logic               frame_done,
  output logic [CNT_W-1:0]   pad_beats
`ifdef AXIS_PAD_TRUNC_EN
  ,
  output logic [CNT_W-1:0]   drop_beats
`endif
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  pad_state_e        state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [CNT_W-1:0]  len_q_reg;
  logic [CNT_W-1:0]  pad_cnt_reg;
  logic              frame_done_reg;
  logic [CNT_W-1:0]  pad_beats_reg;
`ifdef AXIS_PAD_TRUNC_EN
  logic [CNT_W-1:0]  drop_cnt_reg;
  logic [CNT_W-1:0]  drop_beats_reg;
`endif

  logic              in_ready;
  logic              s_ready;
  logic              emit;
  logic [DATA_W-1:0] emit_data;
  logic              emit_last;
  logic              wr;
  logic              first_beat;
  logic [CNT_W-1:0]  frame_len_min1;
  logic [CNT_W-1:0]  len_eff;
  logic              m_valid;

  assign frame_len_min1 = (frame_len == '0) ? ONE : frame_len;
  // cnt only equals 1 in PASS before the first beat of a frame is written.
  assign first_beat     = (state_reg == ST_PASS) && (cnt_reg == ONE);
  // The first beat must be judged against the length being latched now.
  assign len_eff        = first_beat ? frame_len_min1 : len_q_reg;

  always_comb begin
    s_ready   = 1'b0;
    emit      = 1'b0;
    emit_data = s_axis.tdata;
    emit_last = 1'b0;
    unique case (state_reg)
      ST_PASS: begin
        s_ready = in_ready;
        emit    = s_axis.tvalid;
        if (s_axis.tlast) begin
          emit_last = (cnt_reg >= len_eff);
        end else begin
`ifdef AXIS_PAD_TRUNC_EN
          emit_last = (cnt_reg == len_eff);
`else
          emit_last = 1'b0;
`endif
        end
      end
      ST_PAD: begin
        emit      = 1'b1;
        emit_data = PAD_WORD;
        emit_last = (cnt_reg == len_q_reg);
      end
      default: begin
`ifdef AXIS_PAD_TRUNC_EN
        s_ready = 1'b1;
`else
        s_ready = 1'b0;
`endif
      end
    endcase
  end

  assign wr = in_ready & emit;

  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      state_reg      <= ST_PASS;
      cnt_reg        <= ONE;
      len_q_reg      <= ONE;
      pad_cnt_reg    <= '0;
      frame_done_reg <= 1'b0;
      pad_beats_reg  <= '0;
`ifdef AXIS_PAD_TRUNC_EN
      drop_cnt_reg   <= '0;
      drop_beats_reg <= '0;
`endif
    end else begin
      frame_done_reg <= 1'b0;
      if (wr) begin
        if (first_beat) begin
          len_q_reg <= frame_len_min1;
        end
        if (emit_last) begin
          cnt_reg <= ONE;
        end else if (cnt_reg != '1) begin
          cnt_reg <= cnt_reg + ONE;
        end
      end
      unique case (state_reg)
        ST_PASS: begin
          if (wr) begin
            if (s_axis.tlast && !emit_last) begin
              state_reg <= ST_PAD;
            end else if (s_axis.tlast) begin
              frame_done_reg <= 1'b1;
              pad_beats_reg  <= '0;
              pad_cnt_reg    <= '0;
`ifdef AXIS_PAD_TRUNC_EN
              drop_beats_reg <= '0;
              drop_cnt_reg   <= '0;
            end else if (emit_last) begin
              // Output frame is complete; swallow the rest of the input.
              state_reg <= ST_DROP;
`endif
            end
          end
        end
        ST_PAD: begin
          if (wr) begin
            if (emit_last) begin
              state_reg      <= ST_PASS;
              frame_done_reg <= 1'b1;
              pad_beats_reg  <= pad_cnt_reg + ONE;
              pad_cnt_reg    <= '0;
`ifdef AXIS_PAD_TRUNC_EN
              drop_beats_reg <= '0;
              drop_cnt_reg   <= '0;
`endif
            end else begin
              pad_cnt_reg <= pad_cnt_reg + ONE;
            end
          end
        end
        default: begin
`ifdef AXIS_PAD_TRUNC_EN
          if (s_axis.tvalid) begin
            if (s_axis.tlast) begin
              state_reg      <= ST_PASS;
              frame_done_reg <= 1'b1;
              pad_beats_reg  <= pad_cnt_reg;
              pad_cnt_reg    <= '0;
              drop_beats_reg <= drop_cnt_reg + ONE;
              drop_cnt_reg   <= '0;
            end else begin
              drop_cnt_reg <= drop_cnt_reg + ONE;
            end
          end
`else
          state_reg <= ST_PASS;
`endif
        end
      endcase
    end
  end

  axis_skid_reg #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk       (s_axis_aclk),
    .srst      (s_axis_areset),
    .in_valid  (emit),
    .in_ready  (in_ready),
    .in_data   (emit_data),
    .in_last   (emit_last),
    .out_valid (m_valid),
    .out_ready (m_axis.tready),
    .out_data  (m_axis.tdata),
    .out_last  (m_axis.tlast)
  );

  assign m_axis.tvalid = m_valid;
  assign s_axis.tready = s_ready;
  assign m_axis_hsked  = m_valid & m_axis.tready;
  assign frame_done    = frame_done_reg;
  assign pad_beats     = pad_beats_reg;
`ifdef AXIS_PAD_TRUNC_EN
  assign drop_beats    = drop_beats_reg;
`endif

endmodule

// File: tb/tb_axis_frame_padder.sv
// -----------------------------------------------------------------------------
// tb_axis_frame_padder
// Directed and randomised-timing bench for axis_frame_padder. A frame-level
// model turns each input frame into its expected output beats and statistics;
// one negedge process compares every output handshake and frame_done pulse.
// -----------------------------------------------------------------------------
module tb_axis_frame_padder;
  import axis_pad_pkg::*;

  localparam int DW = 64;
  localparam int CW = 32;
  localparam logic [DW-1:0] PADW = {DW{1'b1}};
`ifdef AXIS_PAD_TRUNC_EN
  localparam bit TRUNC = 1'b1;
`else
  localparam bit TRUNC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [CW-1:0] frame_len = '0;
  logic          hsked;
  logic          frame_done;
  logic [CW-1:0] pad_beats;
`ifdef AXIS_PAD_TRUNC_EN
  logic [CW-1:0] drop_beats;
`endif

  axis_frame_padder_if #(.DATA_W(DW)) s_if ();
  axis_frame_padder_if #(.DATA_W(DW)) m_if ();

  axis_frame_padder #(
    .DATA_W (DW),
    .CNT_W  (CW)
  ) dut (
    .s_axis_aclk   (clk),
    .s_axis_areset (rst),
    .frame_len     (frame_len),
    .s_axis        (s_if.slave),
    .m_axis        (m_if.master),
    .m_axis_hsked  (hsked),
    .frame_done    (frame_done),
    .pad_beats     (pad_beats)
`ifdef AXIS_PAD_TRUNC_EN
    ,
    .drop_beats    (drop_beats)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Expected output stream and per-frame statistics.
  logic [DW-1:0] exp_data[$];
  logic          exp_last[$];
  int            exp_pad[$];
  int            exp_drop[$];
  // Observed output beats (for literal checks).
  logic [DW-1:0] obs_data[$];
  logic          obs_last[$];
  int            fd_count = 0;
  int            last_pad = -1;
  int            last_drop = -1;
  // Input frame under construction.
  logic [DW-1:0] fw[$];
  bit            rand_ready = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: pad up to L, pass or cut long frames.
  task automatic model_frame(input int flen);
    int n;
    int l;
    int out_n;
    n = fw.size();
    l = (flen < 1) ? 1 : flen;
    if (n < l) out_n = l;
    else if (TRUNC) out_n = l;
    else out_n = n;
    for (int i = 0; i < out_n; i++) begin
      exp_data.push_back((i < n) ? fw[i] : PADW);
      exp_last.push_back(i == out_n - 1);
    end
    exp_pad.push_back((n < l) ? (l - n) : 0);
    exp_drop.push_back((TRUNC && n > l) ? (n - l) : 0);
  endtask

  // Output ready generator.
  initial begin
    m_if.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_if.tready = rand_ready ? 1'($urandom_range(1)) : 1'b1;
    end
  end

  // Single compare process.
  logic          stall_pend = 1'b0;
  logic [DW-1:0] stall_data;
  logic          stall_last;
  always @(negedge clk) begin
    if (rst) begin
      stall_pend = 1'b0;
    end else begin
      chk("hsked", hsked, m_if.tvalid & m_if.tready);
      if (stall_pend) begin
        chk("stall_stable", {m_if.tvalid, m_if.tlast, m_if.tdata[61:0]},
            {1'b1, stall_last, stall_data[61:0]});
      end
      stall_pend = m_if.tvalid && !m_if.tready;
      stall_data = m_if.tdata;
      stall_last = m_if.tlast;
      if (m_if.tvalid && m_if.tready) begin
        obs_data.push_back(m_if.tdata);
        obs_last.push_back(m_if.tlast);
        if (exp_data.size() == 0) begin
          chk("unexpected_beat", 64'd1, 64'd0);
        end else begin
          chk("beat_data", m_if.tdata, exp_data.pop_front());
          chk("beat_last", 64'(m_if.tlast), 64'(exp_last.pop_front()));
        end
        $display("beat data=%h last=%0d", m_if.tdata, m_if.tlast);
      end
      if (frame_done) begin
        fd_count++;
        last_pad = int'(pad_beats);
        if (exp_pad.size() == 0) begin
          chk("unexpected_frame_done", 64'd1, 64'd0);
        end else begin
          chk("pad_beats", 64'(pad_beats), 64'(exp_pad.pop_front()));
`ifdef AXIS_PAD_TRUNC_EN
          last_drop = int'(drop_beats);
          chk("drop_beats", 64'(drop_beats), 64'(exp_drop.pop_front()));
`else
          void'(exp_drop.pop_front());
`endif
        end
        $display("frame_done pad=%0d", pad_beats);
      end
    end
  end

  task automatic wait_accept();
    int t;
    logic ok;
    t = 0;
    forever begin
      @(negedge clk);
      ok = s_if.tready;
      @(posedge clk);
      #1;
      if (ok) break;
      t++;
      if (t > 2000) begin
        chk("accept_timeout", 64'd1, 64'd0);
        break;
      end
    end
  endtask

  task automatic send_frame(input int flen, input int new_len, input int gap_pct);
    int n;
    n = fw.size();
    model_frame(flen);
    frame_len = CW'(flen);
    for (int i = 0; i < n; i++) begin
      while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
        s_if.tvalid = 1'b0;
        @(posedge clk);
        #1;
      end
      s_if.tvalid = 1'b1;
      s_if.tdata  = fw[i];
      s_if.tlast  = (i == n - 1);
      wait_accept();
      if (i == 0) frame_len = CW'(new_len);
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  task automatic fill_rand(input int n);
    fw.delete();
    for (int i = 0; i < n; i++) fw.push_back({$urandom, $urandom});
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_data.size() != 0 || exp_pad.size() != 0) && t < 5000) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("drain_pending", 64'(exp_data.size() + exp_pad.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_ready_after_reset();
    int t;
    t = 0;
    while (!s_if.tready && t < 10) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("ready_after_reset", 64'(s_if.tready), 64'd1);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got=timeout expected=finish");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int fd0;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tlast  = 1'b0;

    // Reset values.
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
    chk("rst_m_tlast", 64'(m_if.tlast), 64'd0);
    chk("rst_m_tdata", m_if.tdata, 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_pad_beats", 64'(pad_beats), 64'd0);
    chk("rst_s_tready", 64'(s_if.tready), 64'd0);
`ifdef AXIS_PAD_TRUNC_EN
    chk("rst_drop_beats", 64'(drop_beats), 64'd0);
`endif
    rst = 1'b0;
    wait_ready_after_reset();

    // 2-beat frame padded to 4.
    obs_data.delete(); obs_last.delete(); fd0 = fd_count;
    fw = '{64'h0000_0000_0000_000A, 64'h0000_0000_0000_000B};
    send_frame(4, 4, 0);
    drain();
    chk("t1_len", 64'(obs_data.size()), 64'd4);
    chk("t1_beat1", (obs_data.size() > 1) ? obs_data[1] : 64'd0, 64'h0000_0000_0000_000B);
    chk("t1_beat3", (obs_data.size() > 2) ? obs_data[2] : 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t1_last4", (obs_last.size() > 3) ? 64'(obs_last[3]) : 64'd0, 64'd1);
    chk("t1_last2", (obs_last.size() > 1) ? 64'(obs_last[1]) : 64'd1, 64'd0);
    chk("t1_pad", 64'(last_pad), 64'd2);
    chk("t1_fd", 64'(fd_count - fd0), 64'd1);

    // Exact-length frame.
    obs_data.delete(); obs_last.delete();
    fill_rand(3);
    send_frame(3, 3, 0);
    drain();
    chk("t2_len", 64'(obs_data.size()), 64'd3);
    chk("t2_pad", 64'(last_pad), 64'd0);

    // Overlong frame.
    obs_data.delete(); obs_last.delete();
    fill_rand(5);
    send_frame(2, 2, 0);
    drain();
`ifdef AXIS_PAD_TRUNC_EN
    chk("t3_len", 64'(obs_data.size()), 64'd2);
    chk("t3_drop", 64'(last_drop), 64'd3);
`else
    chk("t3_len", 64'(obs_data.size()), 64'd5);
    chk("t3_last5", (obs_last.size() > 4) ? 64'(obs_last[4]) : 64'd0, 64'd1);
`endif

    // Random stalls and gaps.
    rand_ready = 1'b1;
    fd0 = fd_count;
    for (int f = 0; f < 100; f++) begin
      fill_rand(int'($urandom_range(8, 1)));
      send_frame(5, 5, 30);
    end
    drain();
    rand_ready = 1'b0;
    chk("rand_frames", 64'(fd_count - fd0), 64'd100);

    // frame_len change after the first beat.
    obs_data.delete(); obs_last.delete();
    fw = '{64'h55};
    send_frame(4, 2, 0);
    fw = '{64'h66};
    send_frame(2, 2, 0);
    drain();
    chk("t5_len", 64'(obs_data.size()), 64'd6);
    chk("t5_last4", (obs_last.size() > 3) ? 64'(obs_last[3]) : 64'd0, 64'd1);
    chk("t5_beat5", (obs_data.size() > 4) ? obs_data[4] : 64'd0, 64'h66);

    // Reset in the middle of padding.
    obs_data.delete(); obs_last.delete();
    fw = '{64'h77};
    send_frame(4, 4, 0);
    begin
      int t;
      t = 0;
      while (obs_data.size() < 2 && t < 100) begin
        @(posedge clk);
        t++;
      end
    end
    #1;
    rst = 1'b1;
    exp_data.delete(); exp_last.delete(); exp_pad.delete(); exp_drop.delete();
    @(posedge clk);
    #1;
    chk("mid_rst_tvalid", 64'(m_if.tvalid), 64'd0);
    chk("mid_rst_tready", 64'(s_if.tready), 64'd0);
    rst = 1'b0;
    wait_ready_after_reset();
    obs_data.delete(); obs_last.delete();
    fw = '{64'h1234};
    send_frame(1, 1, 0);
    drain();
    chk("t6_len", 64'(obs_data.size()), 64'd1);
    chk("t6_data", (obs_data.size() > 0) ? obs_data[0] : 64'd0, 64'h1234);
    chk("t6_last", (obs_last.size() > 0) ? 64'(obs_last[0]) : 64'd0, 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
